csa_accum_resolve: RTL and testbench
====================================

CSA_ACCUM_RESOLVE -- requirements
Module: csa_accum_resolve

Interface
REQ-001 Parameter IN_W, default 4, operand width.
REQ-002 Parameter ACC_W, default 8, accumulator and result width.
REQ-003 Parameter MAX_OPS, default 15, maximum operands per job; MAX_OPS*(2^IN_W-1) SHALL fit in ACC_W bits.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  operand present.
REQ-007 in_ready  output  1  block accepts an operand.
REQ-008 in_data  input  IN_W  unsigned operand.
REQ-009 in_last  input  1  marks the final operand of a job.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 out_sum  output  ACC_W  resolved sum of the job.
REQ-013 out_count  output  4  number of operands in the job.

Function
REQ-014 The block SHALL have three states: ACCUM, RESOLVE and DONE.
REQ-015 An operand transfer SHALL occur on an edge where in_valid and in_ready are both 1; in_ready SHALL equal 1 only in ACCUM.
REQ-016 On each transfer, sum_r SHALL become sum_r^car_r^x, and car_r SHALL become maj(sum_r,car_r,x)<<1 truncated to ACC_W bits, where x is in_data zero-extended; the count SHALL increment by 1.
REQ-017 A transfer with in_last=1, or the transfer that brings the count to MAX_OPS, SHALL move the state ACCUM->RESOLVE with bit index 0 and ripple carry 0.
REQ-018 RESOLVE SHALL resolve one bit per cycle: res[i] = s[i]^c[i]^cin, then cin = maj(s[i],c[i],cin); after bit ACC_W-1 the state SHALL move to DONE, and the final cin SHALL be discarded.
REQ-019 out_valid SHALL be 1 exactly in DONE, first ACC_W cycles after the accepting edge (8 with the defaults).
REQ-020 out_sum and out_count SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 On an edge with out_valid=1 and out_ready=1, the state SHALL move DONE->ACCUM, and sum_r, car_r and the count SHALL clear to 0.
REQ-022 in_last, in_data and in_valid SHALL be ignored outside ACCUM.
REQ-023 An operand value of 0 SHALL still count toward out_count.

Reset
REQ-024 With rst=1 at an edge, the state SHALL become ACCUM, and sum_r, car_r, the result, the count, the bit index and cin SHALL become 0, regardless of the current state.
REQ-025 After reset, out_valid=0, in_ready=1, out_sum=0 and out_count=0.
REQ-026 A reset during RESOLVE or DONE SHALL discard the job; the next job SHALL be unaffected.

Structure
REQ-027 A shared package SHALL hold IN_W, ACC_W and MAX_OPS defaults and the state enumeration type.
REQ-028 A 1-bit full-adder sub-module fa_cell (a, b, cin -> s, cout) SHALL be instantiated ACC_W times for the CSA step and once for the ripple resolver.

Verification
REQ-029 Three operands 4'b1010, the third with in_last -> out_sum=8'h1E, out_count=3, out_valid 8 cycles after the third accept.
REQ-030 A single operand 4'hF with in_last -> out_sum=8'h0F, out_count=1.
REQ-031 Fifteen operands 4'hF, none with in_last -> forced RESOLVE after the 15th; out_sum=8'hE1, out_count=15.
REQ-032 Hold out_ready=0 for 5 cycles in DONE -> out_sum and out_count are stable and in_ready=0; on release, the next job 4'h3,4'h4(last) -> out_sum=8'h07.
REQ-033 Assert rst during the 4th RESOLVE cycle -> out_valid never rises; the next job 4'h2(last) -> out_sum=8'h02, out_count=1.

Source files
------------

// File: rtl/csa_accum_resolve_pkg.sv
// Shared defaults and state type for the carry-save accumulator with bit-serial resolve.
package csa_accum_resolve_pkg;

    localparam int unsigned IN_W_DEF    = 4;
    localparam int unsigned ACC_W_DEF   = 8;
    localparam int unsigned MAX_OPS_DEF = 15;
    localparam int unsigned CNT_W       = 4;

    typedef enum logic [1:0] {
        StAccum   = 2'd0,
        StResolve = 2'd1,
        StDone    = 2'd2
    } state_e;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder used both for the carry-save step and the serial resolver.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/csa_accum_resolve.sv
// Accumulates operands in carry-save form, then resolves sum+carry one bit per cycle.
module csa_accum_resolve
    import csa_accum_resolve_pkg::*;
#(
    parameter int unsigned IN_W    = IN_W_DEF,
    parameter int unsigned ACC_W   = ACC_W_DEF,
    parameter int unsigned MAX_OPS = MAX_OPS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count
);

    localparam int unsigned IDX_W = (ACC_W > 1) ? $clog2(ACC_W) : 1;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic [ACC_W-1:0]   car_q, car_d;
    logic [ACC_W-1:0]   res_q, res_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               cin_q, cin_d;

    logic [ACC_W-1:0]   x;
    logic [ACC_W-1:0]   csa_s;
    logic [ACC_W-1:0]   csa_cout;
    logic [ACC_W-1:0]   csa_car;
    logic [CNT_W-1:0]   cnt_inc;
    logic               res_bit;
    logic               res_cout;
    logic               unused_top_carry;

    assign x = ACC_W'(in_data);

    for (genvar i = 0; i < ACC_W; i++) begin : g_csa
        fa_cell u_fa (
            .a    (sum_q[i]),
            .b    (car_q[i]),
            .cin  (x[i]),
            .s    (csa_s[i]),
            .cout (csa_cout[i])
        );
    end

    // Carry out of the MSB falls off: the accumulator wraps modulo 2^ACC_W.
    assign csa_car          = {csa_cout[ACC_W-2:0], 1'b0};
    assign unused_top_carry = csa_cout[ACC_W-1];

    fa_cell u_fa_resolve (
        .a    (sum_q[idx_q]),
        .b    (car_q[idx_q]),
        .cin  (cin_q),
        .s    (res_bit),
        .cout (res_cout)
    );

    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign in_ready  = (state_q == StAccum);
    assign out_valid = (state_q == StDone);
    assign out_sum   = res_q;
    assign out_count = cnt_q;

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        car_d   = car_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        cin_d   = cin_q;
        unique case (state_q)
            StAccum: begin
                if (in_valid) begin
                    sum_d = csa_s;
                    car_d = csa_car;
                    cnt_d = cnt_inc;
                    if (in_last || (cnt_inc == CNT_W'(MAX_OPS))) begin
                        state_d = StResolve;
                        idx_d   = '0;
                        cin_d   = 1'b0;
                    end
                end
            end
            StResolve: begin
                res_d[idx_q] = res_bit;
                cin_d        = res_cout;
                idx_d        = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(ACC_W - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StAccum;
                    sum_d   = '0;
                    car_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StAccum;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StAccum;
            sum_q   <= '0;
            car_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            cin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            car_q   <= car_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            cin_q   <= cin_d;
        end
    end

endmodule

// File: tb/tb_csa_accum_resolve.sv
// Directed bench for csa_accum_resolve with hand-computed expected results.
module tb_csa_accum_resolve;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic [3:0] out_count;

    int passed = 0;
    int total  = 0;

    csa_accum_resolve dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic [3:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Counts edges from the accepting edge until out_valid rises.
    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid) break;
        end
        check(tag, n, 8);
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit rose;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_sum", out_sum, 8'h00);
        check("rst_out_count", out_count, 4'd0);

        // Three 4'b1010 operands
        send(4'hA, 1'b0);
        send(4'hA, 1'b0);
        send(4'hA, 1'b1);
        check("j1_in_ready_resolve", in_ready, 0);
        wait_done("j1_latency");
        check("j1_sum", out_sum, 8'h1E);
        check("j1_count", out_count, 4'd3);
        check("j1_in_ready_done", in_ready, 0);
        pop();
        check("j1_pop_valid", out_valid, 0);
        check("j1_pop_ready", in_ready, 1);

        // Single operand, held in DONE for 5 cycles
        send(4'hF, 1'b1);
        wait_done("j2_latency");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("j2_hold_sum", out_sum, 8'h0F);
            check("j2_hold_count", out_count, 4'd1);
            check("j2_hold_in_ready", in_ready, 0);
            check("j2_hold_valid", out_valid, 1);
        end
        pop();
        send(4'h3, 1'b0);
        send(4'h4, 1'b1);
        wait_done("j3_latency");
        check("j3_sum", out_sum, 8'h07);
        check("j3_count", out_count, 4'd2);
        pop();

        // Fifteen 4'hF with no in_last: forced resolve; junk inputs must be ignored
        for (int i = 0; i < 15; i++) send(4'hF, 1'b0);
        in_valid = 1'b1;
        in_data  = 4'hF;
        in_last  = 1'b1;
        wait_done("j4_latency");
        check("j4_sum", out_sum, 8'hE1);
        check("j4_count", out_count, 4'd15);
        pop();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("j4_pop_count", out_count, 4'd0);

        // Zero operands still count
        send(4'h0, 1'b0);
        send(4'h0, 1'b0);
        send(4'h5, 1'b1);
        wait_done("j5_latency");
        check("j5_sum", out_sum, 8'h05);
        check("j5_count", out_count, 4'd3);
        pop();

        // Reset during the 4th RESOLVE cycle
        send(4'h9, 1'b0);
        send(4'h6, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("j6_rst_in_ready", in_ready, 1);
        check("j6_rst_count", out_count, 4'd0);
        check("j6_rst_sum", out_sum, 8'h00);
        rose = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) rose = 1'b1;
        end
        check("j6_no_valid", rose, 0);
        send(4'h2, 1'b1);
        wait_done("j7_latency");
        check("j7_sum", out_sum, 8'h02);
        check("j7_count", out_count, 4'd1);
        pop();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
